// File: rtl/calc1_pkg.sv
// Shared calc1 definitions: command/response codes, driver FSM encoding and request record.
package calc1_pkg;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RESP_NONE    = 2'd0;
   localparam logic [1:0] RESP_OK      = 2'd1;
   localparam logic [1:0] RESP_ERR     = 2'd2;
   localparam logic [1:0] RESP_TIMEOUT = 2'd3;

   // Tag width carried in the buffered request record.
   localparam int CALC1_TAG_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEND1 = 3'd1,
      ST_SEND2 = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HOLD  = 3'd4
   } calc1_state_e;

   typedef struct packed {
      logic [3:0]             cmd;
      logic [31:0]            op1;
      logic [31:0]            op2;
      logic [CALC1_TAG_W-1:0] tag;
   } calc1_req_t;

endpackage

// File: rtl/calc1_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra MSB so full and empty are distinguishable.
module calc1_req_fifo
   import calc1_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  calc1_req_t push_data_i,
   input  logic       pop_i,
   output calc1_req_t pop_data_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   calc1_req_t  mem_q [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty_o  = (wr_ptr_q == rd_ptr_q);
   assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push  = push_i && !full_o;
   assign do_pop   = pop_i && !empty_o;
   assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
   assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

   assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/calc1_port_driver.sv
// Upstream driver for one calc1 port: buffers tagged requests, serialises them onto the
// two-cycle cmd/data protocol, waits for the response (or times out) and returns a completion.
module calc1_port_driver
   import calc1_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TAG_W          = CALC1_TAG_W
) (
   input  logic             c_clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_cmd,
   input  logic [31:0]      req_op1,
   input  logic [31:0]      req_op2,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [1:0]       rsp_resp,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [3:0]       calc_cmd_out,
   output logic [31:0]      calc_data_out,
   input  logic [1:0]       calc_resp_in,
   input  logic [31:0]      calc_data_in,
   output logic             busy
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

   calc1_state_e     state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [31:0]      hold_op2_q, hold_op2_d;
   logic [TAG_W-1:0] hold_tag_q, hold_tag_d;
   logic [3:0]       calc_cmd_q, calc_cmd_d;
   logic [31:0]      calc_data_q, calc_data_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [1:0]       rsp_resp_q, rsp_resp_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

   logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
   calc1_req_t fifo_wdata, fifo_rdata;

   // Both handshakes transfer on a rising edge where valid && ready; valid never waits on ready,
   // and a presented completion holds resp/data/tag stable until it is taken.
   assign req_ready  = !fifo_full;
   assign fifo_push  = req_valid && !fifo_full;
   assign fifo_wdata = '{cmd: req_cmd, op1: req_op1, op2: req_op2, tag: CALC1_TAG_W'(req_tag)};

   calc1_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i      (c_clk),
      .rst_ni     (reset_n),
      .push_i     (fifo_push),
      .push_data_i(fifo_wdata),
      .pop_i      (fifo_pop),
      .pop_data_o (fifo_rdata),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   // calc_* registers are loaded with the value the next state must present.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      hold_op2_d  = hold_op2_q;
      hold_tag_d  = hold_tag_q;
      calc_cmd_d  = CMD_NOP;
      calc_data_d = '0;
      rsp_valid_d = rsp_valid_q;
      rsp_resp_d  = rsp_resp_q;
      rsp_data_d  = rsp_data_q;
      rsp_tag_d   = rsp_tag_q;
      fifo_pop    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               hold_op2_d = fifo_rdata.op2;
               hold_tag_d = TAG_W'(fifo_rdata.tag);
               if (fifo_rdata.cmd != CMD_NOP) begin
                  state_d     = ST_SEND1;
                  calc_cmd_d  = fifo_rdata.cmd;
                  calc_data_d = fifo_rdata.op1;
               end else begin
                  state_d     = ST_HOLD;
                  rsp_valid_d = 1'b1;
                  rsp_resp_d  = RESP_ERR;
                  rsp_data_d  = '0;
                  rsp_tag_d   = TAG_W'(fifo_rdata.tag);
               end
            end
         end
         ST_SEND1: begin
            state_d     = ST_SEND2;
            calc_data_d = hold_op2_q;
         end
         ST_SEND2: begin
            state_d = ST_WAIT;
            timer_d = '0;
         end
         ST_WAIT: begin
            timer_d = timer_q + TMR_W'(1);
            // A response arriving in the final cycle beats the timeout.
            if (calc_resp_in != RESP_NONE) begin
               state_d     = ST_HOLD;
               rsp_valid_d = 1'b1;
               rsp_resp_d  = calc_resp_in;
               rsp_data_d  = (calc_resp_in == RESP_OK) ? calc_data_in : '0;
               rsp_tag_d   = hold_tag_q;
            end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
               state_d     = ST_HOLD;
               rsp_valid_d = 1'b1;
               rsp_resp_d  = RESP_TIMEOUT;
               rsp_data_d  = '0;
               rsp_tag_d   = hold_tag_q;
            end
         end
         ST_HOLD: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               rsp_resp_d  = RESP_NONE;
               rsp_data_d  = '0;
               rsp_tag_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         hold_op2_q  <= '0;
         hold_tag_q  <= '0;
         calc_cmd_q  <= '0;
         calc_data_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_resp_q  <= '0;
         rsp_data_q  <= '0;
         rsp_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         hold_op2_q  <= hold_op2_d;
         hold_tag_q  <= hold_tag_d;
         calc_cmd_q  <= calc_cmd_d;
         calc_data_q <= calc_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tag_q   <= rsp_tag_d;
      end
   end

   assign calc_cmd_out  = calc_cmd_q;
   assign calc_data_out = calc_data_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_tag       = rsp_tag_q;
   assign busy          = (state_q != ST_IDLE);

endmodule
